// File: rtl/conv_2d_pkg.sv
`default_nettype none
// ============================================================================
// Package   : conv2d_pkg
// Purpose   : Shared sizing constants and FSM state type for the conv_2d
//             2D valid-mode convolution engine.
// Contents  : MAX_X, MAX_H, B, OW, port widths, RAM index widths, state_t
// Revision  : 1.0  initial release
// ============================================================================
package conv2d_pkg;

   localparam int MAX_X = 16;   // largest image side
   localparam int MAX_H = 4;    // largest kernel side
   localparam int B     = 8;    // signed sample width
   localparam int OW    = 16;   // signed accumulator / result width

   localparam int X_W   = 11;   // width of the X side-length port
   localparam int H_W   = 3;    // width of the H side-length port

   localparam int XA_W  = $clog2(MAX_X * MAX_X);  // image/result RAM index
   localparam int HA_W  = $clog2(MAX_H * MAX_H);  // kernel RAM index
   localparam int XS_W  = $clog2(MAX_X + 1);      // image row/col counter
   localparam int CNT_W = 2 * X_W;                // load/output counter, holds X*X

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_H  = 3'd1,
      LOAD_X  = 3'd2,
      COMPUTE = 3'd3,
      OUTPUT  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_2d_if.sv
`default_nettype none
// ============================================================================
// Interface : conv_2d_if
// Purpose   : Host-side control, load and result signals of conv_2d.
// Signals   : X, H (geometry), load_h, load_x, start (pulses), data_in (load
//             data), done, data_out (result stream)
// Modports  : master = host, slave = conv_2d
// Revision  : 1.0  initial release
// ============================================================================
interface conv_2d_if;
   import conv2d_pkg::*;

   logic        [X_W-1:0] X;
   logic        [H_W-1:0] H;
   logic                  load_h;
   logic                  load_x;
   logic                  start;
   logic signed [B-1:0]   data_in;
   logic                  done;
   logic signed [OW-1:0]  data_out;

   modport master (
      output X, H, load_h, load_x, start, data_in,
      input  done, data_out
   );

   modport slave (
      input  X, H, load_h, load_x, start, data_in,
      output done, data_out
   );

endinterface
`default_nettype wire

// File: rtl/conv_2d_mac.sv
`default_nettype none
// ============================================================================
// Module    : conv2d_mac
// Purpose   : Signed multiply-accumulate. B x B product sign-extended to OW
//             bits, two's-complement wrap on overflow.
// Ports     : clk, reset (async active-low), en (update accumulator),
//             clear (start a new sum with this product), a, b (operands),
//             sum (combinational value the accumulator takes when enabled)
// Revision  : 1.0  initial release
// ============================================================================
module conv2d_mac
   import conv2d_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clear,
   input  logic signed [B-1:0]  a,
   input  logic signed [B-1:0]  b,
   output logic signed [OW-1:0] sum
);

   logic signed [2*B-1:0] prod;
   logic signed [OW-1:0]  prod_ext;
   logic signed [OW-1:0]  acc;

   assign prod     = a * b;
   assign prod_ext = OW'(prod);
   // sum is exposed so the final term of an output can be stored the same cycle
   assign sum      = clear ? prod_ext : acc + prod_ext;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_2d.sv
`default_nettype none
// ============================================================================
// Module    : conv_2d
// Purpose   : Single-channel 2D valid-mode convolution (correlation form).
//             Serially loads an HxH kernel and an XxX image, computes the
//             (X-H+1)^2 results one MAC per cycle, then streams them.
// Ports     : clk, reset (async active-low), bus (conv_2d_if.slave)
// Revision  : 1.0  initial release
// ============================================================================
module conv_2d
   import conv2d_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   conv_2d_if.slave  bus
);

   state_t state, next_state;

   logic signed [B-1:0]  h_ram [MAX_H*MAX_H];
   logic signed [B-1:0]  x_ram [MAX_X*MAX_X];
   logic signed [OW-1:0] y_ram [MAX_X*MAX_X];

   logic [CNT_W-1:0] cnt;      // load index, result index, then output index
   logic [XS_W-1:0]  r, c;     // output position
   logic [H_W-1:0]   m, n;     // kernel position
   logic             done_q;
   logic signed [OW-1:0] data_q;

   // ---------------- geometry ----------------
   logic [XS_W-1:0]  xs, osz;
   logic [H_W-1:0]   hs;
   logic             geom_ok, last_term, last_out;
   logic [CNT_W-1:0] h_total, x_total, n_out, cnt_inc;

   assign xs      = bus.X[XS_W-1:0];
   assign hs      = bus.H;
   assign geom_ok = (bus.H != '0) && (bus.H <= H_W'(MAX_H)) &&
                    (bus.X <= X_W'(MAX_X)) && (X_W'(bus.H) <= bus.X);
   assign osz     = xs - XS_W'(hs) + XS_W'(1);
   assign h_total = CNT_W'(hs) * CNT_W'(hs);
   assign x_total = CNT_W'(bus.X) * CNT_W'(bus.X);
   // an invalid geometry produces no outputs, only the single done pulse
   assign n_out   = geom_ok ? CNT_W'(osz) * CNT_W'(osz) : '0;
   assign cnt_inc = cnt + CNT_W'(1);

   assign last_term = (m == hs - H_W'(1)) && (n == hs - H_W'(1));
   assign last_out  = (r == osz - XS_W'(1)) && (c == osz - XS_W'(1));

   // ---------------- MAC ----------------
   logic [HA_W-1:0]      h_addr;
   logic [XA_W-1:0]      x_addr;
   logic signed [OW-1:0] mac_sum;
   logic                 mac_en;

   assign h_addr = HA_W'(m) * HA_W'(hs) + HA_W'(n);
   assign x_addr = (XA_W'(r) + XA_W'(m)) * XA_W'(xs) + XA_W'(c) + XA_W'(n);

   conv2d_mac u_mac (
      .clk   (clk),
      .reset (reset),
      .en    (mac_en),
      .clear ((m == '0) && (n == '0)),
      .a     (h_ram[h_addr]),
      .b     (x_ram[x_addr]),
      .sum   (mac_sum)
   );

   // ---------------- FSM ----------------
   logic cap_h, cap_x, out_adv, done_set, done_clr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      cap_h      = 1'b0;
      cap_x      = 1'b0;
      mac_en     = 1'b0;
      out_adv    = 1'b0;
      done_set   = 1'b0;
      done_clr   = 1'b0;
      case (state)
         IDLE: begin
            if      (bus.load_h) next_state = LOAD_H;
            else if (bus.load_x) next_state = LOAD_X;
            else if (bus.start)  next_state = COMPUTE;
         end
         LOAD_H: begin
            cap_h = (cnt < h_total) && (cnt < CNT_W'(MAX_H * MAX_H));
            if (cnt_inc >= h_total) next_state = IDLE;
         end
         LOAD_X: begin
            cap_x = (cnt < x_total) && (cnt < CNT_W'(MAX_X * MAX_X));
            if (cnt_inc >= x_total) next_state = IDLE;
         end
         COMPUTE: begin
            if (!geom_ok) begin
               done_set   = 1'b1;
               next_state = OUTPUT;
            end else begin
               mac_en = 1'b1;
               if (last_term && last_out) begin
                  done_set   = 1'b1;
                  next_state = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (cnt < n_out) begin
               out_adv = 1'b1;
            end else begin
               done_clr   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // ---------------- counters and outputs ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         r      <= '0;
         c      <= '0;
         m      <= '0;
         n      <= '0;
         done_q <= 1'b0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               r   <= '0;
               c   <= '0;
               m   <= '0;
               n   <= '0;
            end
            LOAD_H, LOAD_X: cnt <= cnt_inc;
            COMPUTE: begin
               if (mac_en) begin
                  if (n == hs - H_W'(1)) begin
                     n <= '0;
                     if (m == hs - H_W'(1)) begin
                        m   <= '0;
                        cnt <= cnt_inc;
                        if (c == osz - XS_W'(1)) begin
                           c <= '0;
                           r <= r + XS_W'(1);
                        end else begin
                           c <= c + XS_W'(1);
                        end
                     end else begin
                        m <= m + H_W'(1);
                     end
                  end else begin
                     n <= n + H_W'(1);
                  end
               end
               // output streaming restarts from result index 0
               if (done_set) cnt <= '0;
            end
            OUTPUT: begin
               if (out_adv) begin
                  data_q <= y_ram[cnt[XA_W-1:0]];
                  cnt    <= cnt_inc;
               end
            end
            default: cnt <= '0;
         endcase
         if (done_set)      done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
      end
   end

   // ---------------- RAMs (contents not reset) ----------------
   always_ff @(posedge clk) begin
      if (cap_h)              h_ram[cnt[HA_W-1:0]] <= bus.data_in;
      if (cap_x)              x_ram[cnt[XA_W-1:0]] <= bus.data_in;
      if (mac_en && last_term) y_ram[cnt[XA_W-1:0]] <= mac_sum;
   end

   assign bus.done     = done_q;
   assign bus.data_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_2d.sv
`default_nettype none
// ============================================================================
// Module    : tb_conv_2d
// Purpose   : Directed self-checking bench for conv_2d.
// Revision  : 1.0  initial release
// ============================================================================
module tb_conv_2d;
   import conv2d_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   conv_2d_if bus ();

   conv_2d dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [OW-1:0] got [256];
   logic                 dn  [256];
   logic                 tail_done;
   bit                   timeout;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_kernel(input int h, input int base, input int step);
      bus.H      = 3'(h);
      bus.load_h = 1'b1;
      tick();
      bus.load_h = 1'b0;
      for (int i = 0; i < h * h; i++) begin
         bus.data_in = 8'(base + i * step);
         tick();
      end
   endtask

   task automatic load_image(input int x, input int base, input int step);
      bus.X      = 11'(x);
      bus.load_x = 1'b1;
      tick();
      bus.load_x = 1'b0;
      for (int i = 0; i < x * x; i++) begin
         bus.data_in = 8'(base + i * step);
         tick();
      end
   endtask

   // start, wait for done, capture n_exp outputs; optionally re-pulse start
   task automatic run(input int n_exp, input int poke_at);
      int w;
      timeout   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      w = 0;
      while (bus.done !== 1'b1 && w < 3000) begin
         tick();
         w++;
      end
      if (w >= 3000) timeout = 1'b1;
      if (!timeout) begin
         for (int k = 0; k < n_exp; k++) begin
            if (k == poke_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            got[k] = bus.data_out;
            dn[k]  = bus.done;
         end
      end
      tick();
      tail_done = bus.done;
   endtask

   task automatic test_reset;
      #2 reset = 1'b0;
      #3;
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done);
      end
      n_cmp++;
      if (bus.data_out !== 16'sd0) begin
         n_bad++; $display("FAIL reset_data: got %0d expected 0", bus.data_out);
      end
      tick();
      reset = 1'b1;
      tick();
   endtask

   // h = [1 2;3 4], x(i,j) = 5i+j+1  ->  y(r,c) = 50r + 10c + 51
   task automatic check_scenario1(input string tag);
      int e;
      n_cmp++;
      if (timeout) begin
         n_bad++; $display("FAIL %s_timeout: done never rose", tag);
      end
      for (int k = 0; k < 16; k++) begin
         e = 50 * (k / 4) + 10 * (k % 4) + 51;
         n_cmp++;
         if (got[k] !== 16'(e)) begin
            n_bad++; $display("FAIL %s_y[%0d]: got %0d expected %0d", tag, k, got[k], e);
         end
         n_cmp++;
         if (dn[k] !== 1'b1) begin
            n_bad++; $display("FAIL %s_done[%0d]: got %b expected 1", tag, k, dn[k]);
         end
      end
      n_cmp++;
      if (tail_done !== 1'b0) begin
         n_bad++; $display("FAIL %s_done_fall: got %b expected 0", tag, tail_done);
      end
   endtask

   task automatic test_basic;
      load_kernel(2, 1, 1);
      load_image(5, 1, 1);
      run(16, -1);
      check_scenario1("basic");
      tick();
      n_cmp++;
      if (bus.data_out !== 16'sd231) begin
         n_bad++; $display("FAIL basic_hold: got %0d expected 231", bus.data_out);
      end
   endtask

   task automatic test_image_reload;
      load_image(5, -1, 0);
      run(16, -1);
      n_cmp++;
      if (timeout) begin
         n_bad++; $display("FAIL reload_timeout: done never rose");
      end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (got[k] !== -16'sd10) begin
            n_bad++; $display("FAIL reload_y[%0d]: got %0d expected -10", k, got[k]);
         end
      end
   endtask

   task automatic test_kernel_1x1;
      load_kernel(1, 3, 0);
      load_image(3, 1, 1);
      run(9, -1);
      n_cmp++;
      if (timeout) begin
         n_bad++; $display("FAIL k1_timeout: done never rose");
      end
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (got[k] !== 16'(3 * (k + 1))) begin
            n_bad++; $display("FAIL k1_y[%0d]: got %0d expected %0d", k, got[k], 3 * (k + 1));
         end
      end
      n_cmp++;
      if (tail_done !== 1'b0) begin
         n_bad++; $display("FAIL k1_done_fall: got %b expected 0", tail_done);
      end
   endtask

   task automatic test_wrap;
      load_kernel(4, 127, 0);
      load_image(4, 127, 0);
      run(1, -1);
      n_cmp++;
      if (timeout || got[0] !== -16'sd4080) begin
         n_bad++; $display("FAIL wrap_y0: got %0d expected -4080 (timeout=%0d)", got[0], timeout);
      end
   endtask

   task automatic test_invalid;
      bus.H = 3'd5;             // larger than MAX_H and larger than X=4
      run(0, -1);
      n_cmp++;
      if (timeout || tail_done !== 1'b0) begin
         n_bad++; $display("FAIL inv_h5_pulse: timeout=%0d done_after=%b expected one-cycle pulse", timeout, tail_done);
      end
      n_cmp++;
      if (bus.data_out !== -16'sd4080) begin
         n_bad++; $display("FAIL inv_h5_data: got %0d expected -4080", bus.data_out);
      end
      bus.H = 3'd0;
      run(0, -1);
      n_cmp++;
      if (timeout || tail_done !== 1'b0) begin
         n_bad++; $display("FAIL inv_h0_pulse: timeout=%0d done_after=%b expected one-cycle pulse", timeout, tail_done);
      end
   endtask

   task automatic test_reset_mid_load;
      bus.H      = 3'd2;
      bus.X      = 11'd5;
      bus.load_x = 1'b1;
      tick();
      bus.load_x = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.data_in = 8'(100 + i);
         tick();
      end
      reset = 1'b0;
      #2;
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_bad++; $display("FAIL midrst_done: got %b expected 0", bus.done);
      end
      n_cmp++;
      if (bus.data_out !== 16'sd0) begin
         n_bad++; $display("FAIL midrst_data: got %0d expected 0", bus.data_out);
      end
      tick();
      reset = 1'b1;
      tick();
      load_kernel(2, 1, 1);
      load_image(5, 1, 1);
      run(16, -1);
      check_scenario1("midrst");
   endtask

   task automatic test_start_during_output;
      run(16, 5);
      check_scenario1("restart");
   endtask

   initial begin
      bus.X       = '0;
      bus.H       = '0;
      bus.load_h  = 1'b0;
      bus.load_x  = 1'b0;
      bus.start   = 1'b0;
      bus.data_in = '0;
      test_reset();
      test_basic();
      test_image_reload();
      test_kernel_1x1();
      test_wrap();
      test_invalid();
      test_reset_mid_load();
      test_start_during_output();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
